// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NUM_REQ requesters.
// One transaction in flight; each is bounded by a ready-timeout watchdog.
module sram_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 11,
  parameter int TIMEOUT = 255,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [IDW-1:0]            grant_id,
  output logic                      busy,
  output logic                      sram_wen,
  output logic                      sram_ren,
  output logic [ADDR_W-1:0]         sram_addr,
  output logic [DATA_W-1:0]         sram_wdata,
  input  logic [DATA_W-1:0]         sram_rdata,
  input  logic                      sram_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDW-1:0]       r_ptr;
  logic [7:0]           r_cnt;
  logic [NUM_REQ-1:0]   r_done;
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_err;
  logic [IDW-1:0]       r_gid;
  logic                 r_busy;
  logic                 r_wen;
  logic                 r_ren;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;

  logic                 w_found;
  logic [IDW-1:0]       w_win;
  logic                 w_timeout;
  logic [IDW-1:0]       w_ptr;
  logic [7:0]           w_cnt;
  logic [NUM_REQ-1:0]   w_done;
  logic [DATA_W-1:0]    w_rdata;
  logic                 w_err;
  logic [IDW-1:0]       w_gid;
  logic                 w_busy;
  logic                 w_wen;
  logic                 w_ren;
  logic [ADDR_W-1:0]    w_addr;
  logic [DATA_W-1:0]    w_wdata;

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    int j;
    w_found = 1'b0;
    w_win   = '0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_found && req_valid[j]) begin
        w_found = 1'b1;
        w_win   = IDW'(j);
      end
    end
  end

  assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_found) w_state_nxt = S_BUSY;
      S_BUSY: if (sram_ready || w_timeout) w_state_nxt = S_RESP;
      S_RESP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of every registered output; ready beats the watchdog.
  always_comb begin
    w_ptr   = r_ptr;
    w_cnt   = r_cnt;
    w_done  = '0;
    w_rdata = r_rdata;
    w_err   = r_err;
    w_gid   = r_gid;
    w_busy  = r_busy;
    w_wen   = r_wen;
    w_ren   = r_ren;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_wen   = req_we[w_win];
          w_ren   = ~req_we[w_win];
          w_addr  = req_addr[int'(w_win)*ADDR_W +: ADDR_W];
          w_wdata = req_wdata[int'(w_win)*DATA_W +: DATA_W];
          w_gid   = w_win;
          w_busy  = 1'b1;
          w_cnt   = '0;
        end
      end
      S_BUSY: begin
        if (sram_ready) begin
          w_rdata       = r_wen ? '0 : sram_rdata;
          w_err         = 1'b0;
          w_wen         = 1'b0;
          w_ren         = 1'b0;
          w_done[r_gid] = 1'b1;
        end else if (w_timeout) begin
          w_rdata       = '0;
          w_err         = 1'b1;
          w_wen         = 1'b0;
          w_ren         = 1'b0;
          w_done[r_gid] = 1'b1;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      S_RESP: begin
        w_err  = 1'b0;
        w_busy = 1'b0;
        w_ptr  = (r_gid == IDW'(NUM_REQ - 1)) ? '0 : r_gid + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_done  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_gid   <= '0;
      r_busy  <= 1'b0;
      r_wen   <= 1'b0;
      r_ren   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_ptr   <= w_ptr;
      r_cnt   <= w_cnt;
      r_done  <= w_done;
      r_rdata <= w_rdata;
      r_err   <= w_err;
      r_gid   <= w_gid;
      r_busy  <= w_busy;
      r_wen   <= w_wen;
      r_ren   <= w_ren;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
    end
  end

  assign req_done   = r_done;
  assign rsp_rdata  = r_rdata;
  assign rsp_err    = r_err;
  assign grant_id   = r_gid;
  assign busy       = r_busy;
  assign sram_wen   = r_wen;
  assign sram_ren   = r_ren;
  assign sram_addr  = r_addr;
  assign sram_wdata = r_wdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM responder, transaction-rule model, directed tests.
module tb_sram_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 11;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_done;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [1:0]      grant_id;
  logic            busy;
  logic            sram_wen;
  logic            sram_ren;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_wdata;
  logic [DW-1:0]   sram_rdata;
  logic            sram_ready;

  sram_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .grant_id(grant_id), .busy(busy),
    .sram_wen(sram_wen), .sram_ren(sram_ren),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SRAM responder: ready in the lat-th strobed cycle; lat<=0 never answers.
  int lat;
  logic spur;
  logic [DW-1:0] mem [0:2047];
  int age;
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    mem[11'h055] = 16'hBEEF;
    sram_ready = 1'b0;
    sram_rdata = '0;
    age = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        age = 0;
        sram_ready = 1'b0;
      end else if (sram_wen || sram_ren) begin
        age++;
        sram_rdata = DW'($urandom);
        if (lat > 0 && age == lat) begin
          sram_ready = 1'b1;
          if (sram_ren) sram_rdata = mem[sram_addr];
          else mem[sram_addr] = sram_wdata;
        end else begin
          sram_ready = 1'b0;
        end
      end else begin
        age = 0;
        sram_ready = spur;
        sram_rdata = DW'($urandom);
      end
    end
  end

  // Winner = valid requester with the smallest rotated distance from ptr.
  function automatic int pick(input logic [N-1:0] v, input int p);
    int b = -1;
    int bd = N;
    for (int i = 0; i < N; i++)
      if (v[i] && ((i - p + N) % N) < bd) begin
        bd = (i - p + N) % N;
        b = i;
      end
    return b;
  endfunction

  int m_st, m_ptr, m_age, m_win;
  logic m_we;
  logic [N-1:0] e_done;
  logic [DW-1:0] e_rdata, e_wdata;
  logic [AW-1:0] e_addr;
  logic e_err, e_busy, e_wen, e_ren;
  logic [1:0] e_gid;

  assign m_win = pick(req_valid, m_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= 0; m_ptr <= 0; m_age <= 0; m_we <= 1'b0;
      e_done <= '0; e_rdata <= '0; e_err <= 1'b0; e_gid <= '0;
      e_busy <= 1'b0; e_wen <= 1'b0; e_ren <= 1'b0;
      e_addr <= '0; e_wdata <= '0;
    end else if (m_st == 0) begin
      if (|req_valid) begin
        m_we    <= req_we[m_win];
        e_wen   <= req_we[m_win];
        e_ren   <= !req_we[m_win];
        e_addr  <= req_addr[m_win*AW +: AW];
        e_wdata <= req_wdata[m_win*DW +: DW];
        e_gid   <= 2'(m_win);
        e_busy  <= 1'b1;
        m_age   <= 0;
        m_st    <= 1;
      end
    end else if (m_st == 1) begin
      m_age <= m_age + 1;
      if (sram_ready || m_age + 1 == TO) begin
        e_done  <= 4'(1 << e_gid);
        e_rdata <= (sram_ready && !m_we) ? sram_rdata : '0;
        e_err   <= !sram_ready;
        e_wen   <= 1'b0;
        e_ren   <= 1'b0;
        m_st    <= 2;
      end
    end else begin
      e_done <= '0;
      e_err  <= 1'b0;
      e_busy <= 1'b0;
      m_ptr  <= (int'(e_gid) + 1) % N;
      m_st   <= 0;
    end
  end

  always @(negedge clk) begin
    check("cycle",
      {req_done, rsp_rdata, rsp_err, grant_id, busy,
       sram_wen, sram_ren, sram_addr, sram_wdata},
      {e_done, e_rdata, e_err, e_gid, e_busy,
       e_wen, e_ren, e_addr, e_wdata});
    check("mutex", 64'(sram_wen & sram_ren), 0);
  end

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic wait_done(input int maxc);
    bit ok = 0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (|req_done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("done_timeout", 0, 1);
  endtask

  task automatic edge_in();
    @(posedge clk);
    #1;
  endtask

  int rr_exp [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int cnt;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    lat = 1; spur = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outputs",
      {req_done, rsp_rdata, rsp_err, grant_id, busy,
       sram_wen, sram_ren, sram_addr, sram_wdata}, 0);
    edge_in(); rst_n = 1'b1;

    lat = 2;
    set_req(1, 1, 0, 11'h055, 0);
    @(negedge clk); check("ren_before_grant", 64'(sram_ren), 0);
    @(negedge clk); check("ren_after_grant", 64'(sram_ren), 1);
    check("rd_addr", sram_addr, 'h055);
    wait_done(20);
    check("rd_done", req_done, 4'b0010);
    check("rd_data", rsp_rdata, 'hBEEF);
    check("rd_err", 64'(rsp_err), 0);
    check("rd_gid", grant_id, 1);
    edge_in(); set_req(1, 0, 0, 0, 0);

    lat = 1;
    set_req(0, 1, 1, 11'h7FF, 16'h1234);
    wait_done(20);
    check("wr_done", req_done, 4'b0001);
    check("wr_rdata", rsp_rdata, 0);
    edge_in(); req_we[0] = 1'b0;
    wait_done(20);
    check("rb_done", req_done, 4'b0001);
    check("rb_data", rsp_rdata, 'h1234);
    edge_in(); set_req(0, 0, 0, 0, 0);

    set_req(3, 1, 1, 11'h0AA, 16'h5A5A);
    wait_done(20);
    check("wr3_gid", grant_id, 3);
    edge_in(); set_req(3, 0, 0, 0, 0);

    set_req(0, 1, 0, 11'h055, 0);
    set_req(1, 1, 0, 11'h7FF, 0);
    set_req(2, 1, 0, 11'h123, 0);
    set_req(3, 1, 0, 11'h0AA, 0);
    for (int t = 0; t < 8; t++) begin
      wait_done(20);
      check("rr_gid", grant_id, rr_exp[t]);
      if (t == 3) check("rr_data3", rsp_rdata, 'h5A5A);
    end
    edge_in(); req_valid = '0;

    spur = 1'b1;
    repeat (3) @(negedge clk);
    check("spur_idle", {busy, req_done}, 0);
    edge_in(); spur = 1'b0;

    lat = -1;
    set_req(2, 1, 0, 11'h100, 0);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sram_ren || sram_wen) cnt++;
      if (|req_done) break;
    end
    check("to_cycles", cnt, TO);
    check("to_done", req_done, 4'b0100);
    check("to_err", 64'(rsp_err), 1);
    check("to_data", rsp_rdata, 0);
    edge_in();
    lat = 3;
    set_req(2, 1, 0, 11'h055, 0);
    wait_done(20);
    check("post_to_data", rsp_rdata, 'hBEEF);
    check("post_to_err", 64'(rsp_err), 0);
    edge_in(); set_req(2, 0, 0, 0, 0);

    lat = TO;
    set_req(1, 1, 0, 11'h7FF, 0);
    wait_done(30);
    check("coin_done", req_done, 4'b0010);
    check("coin_err", 64'(rsp_err), 0);
    check("coin_data", rsp_rdata, 'h1234);
    edge_in(); set_req(1, 0, 0, 0, 0);

    lat = -1;
    set_req(3, 1, 0, 11'h0AA, 0);
    repeat (3) @(negedge clk);
    check("mid_busy", 64'(sram_ren), 1);
    #2 rst_n = 1'b0;
    #1 check("rst_async",
      {req_done, rsp_rdata, rsp_err, grant_id, busy,
       sram_wen, sram_ren, sram_addr, sram_wdata}, 0);
    set_req(0, 1, 0, 11'h055, 0);
    lat = 1;
    edge_in(); rst_n = 1'b1;
    wait_done(20);
    check("rst_first_gid", grant_id, 0);
    check("rst_first_done", req_done, 4'b0001);
    check("rst_first_data", rsp_rdata, 'hBEEF);
    edge_in(); set_req(0, 0, 0, 0, 0);
    wait_done(20);
    check("rst_second_done", req_done, 4'b1000);
    check("rst_second_data", rsp_rdata, 'h5A5A);
    edge_in(); set_req(3, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
